// File: rtl/ddr4_v2_2_20_mc_act_arb.sv
// Activate-command arbiter for the four group ports: timing-qualified
// round-robin pick with starvation override and a post-grant idle gap.

module ddr4_v2_2_20_mc_act_arb_stv #(
  parameter int STARVE_LIMIT = 15,
  parameter int STV_BITS     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic won,
  input  logic any_pick,
  output logic starve
);
  localparam logic [STV_BITS-1:0] LIM = STV_BITS'(STARVE_LIMIT);

  logic [STV_BITS-1:0] cnt, cnt_nxt;

  // Only cycles where some other port actually won count as lost arbitration.
  always_comb begin
    cnt_nxt = cnt;
    if (won || !req)                 cnt_nxt = '0;
    else if (any_pick && cnt != LIM) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      starve <= (STARVE_LIMIT != 0) && (cnt_nxt == LIM);
    end
  end
endmodule

module ddr4_v2_2_20_mc_act_arb #(
  parameter int  RKBITS       = 2,
  parameter int  LR_WIDTH     = 1,
  parameter int  RANK_SLAB    = 4,
  parameter int  ACT_GAP      = 1,
  parameter int  STARVE_LIMIT = 15,
  parameter int  STV_BITS     = 4,
  parameter real TCQ          = 0.1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            actReq,
  input  logic [3:0]            actReqT,
  input  logic [RKBITS*4-1:0]   cmdRank,
  input  logic [4*LR_WIDTH-1:0] cmdLRank,
  input  logic                  actBlock,
  output logic [3:0]            act_winPort_nxt,
  output logic [RANK_SLAB-1:0]  act_rank_update,
  output logic [3:0]            winPort,
  output logic [RKBITS-1:0]     winRank,
  output logic [LR_WIDTH-1:0]   winLRank,
  output logic [3:0]            starve
);
  localparam int GW = (ACT_GAP > 0) ? $clog2(ACT_GAP + 1) : 1;

  if ((TCQ < 0.0) || (STARVE_LIMIT >= (1 << STV_BITS))) begin : g_param_err
  end

  logic [1:0]          ptr;
  logic [GW-1:0]       gap;
  logic [3:0]          elig, cand;
  logic                pick_vld;
  logic [1:0]          pick_idx, idx;
  logic [RKBITS-1:0]   pick_rank;
  logic [LR_WIDTH-1:0] pick_lrank;

  assign elig = actReq & actReqT & {4{~actBlock & (gap == '0) & rst_n}};
  // Starving ports pre-empt only if they are themselves eligible this cycle.
  assign cand = (|(elig & starve)) ? (elig & starve) : elig;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!pick_vld && cand[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  assign pick_rank       = cmdRank[RKBITS*pick_idx +: RKBITS];
  assign pick_lrank      = cmdLRank[LR_WIDTH*pick_idx +: LR_WIDTH];
  assign act_winPort_nxt = pick_vld ? (4'b0001 << pick_idx) : 4'b0000;

  // Out-of-slab rank values decode to no update.
  always_comb begin
    act_rank_update = '0;
    for (int r = 0; r < RANK_SLAB; r++)
      act_rank_update[r] = pick_vld && (32'(pick_rank) == r);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      winPort  <= '0;
      winRank  <= '0;
      winLRank <= '0;
      ptr      <= '0;
      gap      <= '0;
    end else begin
      winPort  <= act_winPort_nxt;
      winRank  <= pick_vld ? pick_rank  : '0;
      winLRank <= pick_vld ? pick_lrank : '0;
      if (pick_vld) ptr <= pick_idx + 2'd1;
      if (pick_vld)          gap <= GW'(ACT_GAP);
      else if (gap != '0)    gap <= gap - 1'b1;
    end
  end

  for (genvar p = 0; p < 4; p++) begin : g_stv
    ddr4_v2_2_20_mc_act_arb_stv #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .STV_BITS     (STV_BITS)
    ) u_stv (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (actReq[p]),
      .won      (act_winPort_nxt[p]),
      .any_pick (pick_vld),
      .starve   (starve[p])
    );
  end
endmodule

// File: tb/tb_ddr4_v2_2_20_mc_act_arb.sv
// Directed + randomized bench for the activate arbiter against a
// cycle-level behavioural model of the arbitration rules.

module tb_ddr4_v2_2_20_mc_act_arb;
  localparam int RKB = 3;
  localparam int LRW = 1;
  localparam int RS  = 4;
  localparam int GAP = 1;
  localparam int SL  = 3;
  localparam int SB  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       actReq, actReqT;
  logic [RKB*4-1:0] cmdRank;
  logic [4*LRW-1:0] cmdLRank;
  logic             actBlock;
  logic [3:0]       act_winPort_nxt;
  logic [RS-1:0]    act_rank_update;
  logic [3:0]       winPort;
  logic [RKB-1:0]   winRank;
  logic [LRW-1:0]   winLRank;
  logic [3:0]       starve;

  int checks = 0;
  int failures = 0;

  // model state
  int       m_ptr, m_gap;
  int       m_cnt [4];
  bit [3:0] m_starve, m_win;
  int       m_rank, m_lrank;

  always #5 clk = ~clk;

  ddr4_v2_2_20_mc_act_arb #(
    .RKBITS(RKB), .LR_WIDTH(LRW), .RANK_SLAB(RS), .ACT_GAP(GAP),
    .STARVE_LIMIT(SL), .STV_BITS(SB), .TCQ(0.1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .actReq(actReq), .actReqT(actReqT),
    .cmdRank(cmdRank), .cmdLRank(cmdLRank), .actBlock(actBlock),
    .act_winPort_nxt(act_winPort_nxt), .act_rank_update(act_rank_update),
    .winPort(winPort), .winRank(winRank), .winLRank(winLRank), .starve(starve)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; checks, advances model
  // across the next rising edge, and returns at the following falling edge.
  task automatic step();
    bit [3:0] elig, cand, exp_nxt;
    bit [RS-1:0] exp_ru;
    int pk, rk, lrk;
    #1;
    elig = (rst_n && !actBlock && m_gap == 0) ? (actReq & actReqT) : 4'b0;
    cand = ((elig & m_starve) != 0) ? (elig & m_starve) : elig;
    pk = -1;
    for (int k = 0; k < 4; k++)
      if (pk < 0 && cand[(m_ptr + k) % 4]) pk = (m_ptr + k) % 4;
    exp_nxt = (pk < 0) ? 4'b0 : 4'(1 << pk);
    rk  = (pk < 0) ? 0 : int'((cmdRank >> (RKB * pk)) & 12'h7);
    lrk = (pk < 0) ? 0 : int'(cmdLRank[pk]);
    exp_ru = (pk >= 0 && rk < RS) ? RS'(1 << rk) : '0;

    chk("act_winPort_nxt", 32'(act_winPort_nxt), 32'(exp_nxt));
    chk("act_rank_update", 32'(act_rank_update), 32'(exp_ru));
    chk("winPort",  32'(winPort),  32'(m_win));
    chk("winRank",  32'(winRank),  32'(m_rank));
    chk("winLRank", 32'(winLRank), 32'(m_lrank));
    chk("starve",   32'(starve),   32'(m_starve));

    if (!rst_n) begin
      m_ptr = 0; m_gap = 0; m_win = 0; m_rank = 0; m_lrank = 0; m_starve = 0;
      for (int p = 0; p < 4; p++) m_cnt[p] = 0;
    end else begin
      m_win   = exp_nxt;
      m_rank  = (pk < 0) ? 0 : rk;
      m_lrank = (pk < 0) ? 0 : lrk;
      if (pk >= 0) m_ptr = (pk + 1) % 4;
      m_gap = (pk >= 0) ? GAP : ((m_gap > 0) ? m_gap - 1 : 0);
      for (int p = 0; p < 4; p++) begin
        if (p == pk || !actReq[p]) m_cnt[p] = 0;
        else if (pk >= 0 && m_cnt[p] < SL) m_cnt[p]++;
        m_starve[p] = (SL != 0) && (m_cnt[p] == SL);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; actReq = 4'hF; actReqT = 4'hF; actBlock = 1'b0;
    cmdRank = {3'd3, 3'd2, 3'd1, 3'd0}; cmdLRank = 4'b1010;
    m_ptr = 0; m_gap = 0; m_win = 0; m_rank = 0; m_lrank = 0; m_starve = 0;
    for (int p = 0; p < 4; p++) m_cnt[p] = 0;
    @(negedge clk); @(negedge clk);

    // reset held with full requests
    repeat (3) step();
    rst_n = 1'b1;

    // round-robin under constant full requests
    repeat (10) step();

    // timing mask: only port 2 timing-OK, rank 2
    actReqT = 4'b0100;
    repeat (3) step();

    // actBlock for two cycles, then release
    actReqT = 4'hF;
    actBlock = 1'b1;
    repeat (2) step();
    actBlock = 1'b0;
    repeat (4) step();

    // starvation: port 3 requests but is never timing-OK until flagged
    actReqT = 4'b0111;
    repeat (10) step();
    actReqT = 4'hF;
    repeat (6) step();

    // out-of-slab rank on every port
    cmdRank = {3'd5, 3'd6, 3'd7, 3'd5};
    repeat (4) step();

    // randomized traffic, with an occasional mid-run reset
    for (int n = 0; n < 400; n++) begin
      actReq   = 4'($urandom);
      actReqT  = 4'($urandom) | 4'($urandom);
      actBlock = ($urandom_range(0, 7) == 0);
      cmdRank  = 12'($urandom);
      cmdLRank = 4'($urandom);
      rst_n    = (n % 150 == 149) ? 1'b0 : 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
